// File: rtl/btn_debounce.sv
// btn_debounce: multi-channel push-button conditioner.
// Per channel: two-flop synchroniser, stability counter, debounced level,
// one-cycle rise/fall pulses, a sticky press flag, and an OR-reduced irq.
module btn_debounce #(
    parameter int unsigned channels        = 4,
    parameter int unsigned debounce_cycles = 1000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [channels-1:0] btn_i,
    output logic [channels-1:0] btn_o,
    output logic [channels-1:0] rise_o,
    output logic [channels-1:0] fall_o,
    output logic [channels-1:0] evt_o,
    input  logic [channels-1:0] evt_clr_i,
    output logic                irq_o
);

    localparam int unsigned CW = (debounce_cycles > 1) ? $clog2(debounce_cycles) : 1;
    localparam logic [CW-1:0] TERM = CW'(debounce_cycles - 1);

    // STABLE: synchronised input matches the debounced level.
    // PENDING: it differs and the counter is qualifying the change.
    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } chan_state_t;

    logic [channels-1:0] s1;
    logic [channels-1:0] s2;
    logic [CW-1:0]       cnt      [channels];
    logic [CW-1:0]       cnt_next [channels];
    chan_state_t         ch_state [channels];
    logic [channels-1:0] btn_next;
    logic [channels-1:0] rise_next;
    logic [channels-1:0] fall_next;
    logic [channels-1:0] evt_next;

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_i;
            s2 <= s1;
        end
    end

    // Per-channel debounce decision, edge pulses and sticky event flags.
    always_comb begin
        btn_next  = btn_o;
        rise_next = '0;
        fall_next = '0;
        for (int unsigned n = 0; n < channels; n++) begin
            cnt_next[n] = '0;
            ch_state[n] = (s2[n] == btn_o[n]) ? STABLE : PENDING;
            case (ch_state[n])
                STABLE: cnt_next[n] = '0;
                PENDING: begin
                    if (cnt[n] == TERM) begin
                        cnt_next[n]  = '0;
                        btn_next[n]  = s2[n];
                        rise_next[n] = s2[n];
                        fall_next[n] = ~s2[n];
                    end else begin
                        cnt_next[n] = cnt[n] + 1'b1;
                    end
                end
                default: cnt_next[n] = '0;
            endcase
        end
        // A rise on the same edge as a clear keeps the flag set.
        evt_next = (evt_o & ~evt_clr_i) | rise_next;
    end

    // Registered outputs and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_o  <= '0;
            rise_o <= '0;
            fall_o <= '0;
            evt_o  <= '0;
            irq_o  <= 1'b0;
            for (int unsigned n = 0; n < channels; n++) begin
                cnt[n] <= '0;
            end
        end else begin
            btn_o  <= btn_next;
            rise_o <= rise_next;
            fall_o <= fall_next;
            evt_o  <= evt_next;
            irq_o  <= |evt_next;
            for (int unsigned n = 0; n < channels; n++) begin
                cnt[n] <= cnt_next[n];
            end
        end
    end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Multi-channel push-button conditioner that sits directly upstream of the GPIO peripheral's `boton` inputs in the LM32 SoC top level. It synchronises raw asynchronous board buttons into `clk`, rejects bounce with a per-channel stability counter, and produces:
- clean levels;
- single-cycle rise and fall pulses;
- sticky press-event flags that software clears through the GPIO peripheral, with an OR-reduced interrupt request.

## Interface
Parameters:
- `channels`, 4, number of button channels (1..8).
- `debounce_cycles`, 1000000, clock cycles an input must be stable before the output follows (10 ms at 100 MHz); legal range 2..2^24.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btn_i`  in  `channels`  raw button inputs, asynchronous to `clk`, active-high.
- `btn_o`  out  `channels`  debounced level per channel.
- `rise_o`  out  `channels`  one-cycle pulse on a debounced 0→1 transition.
- `fall_o`  out  `channels`  one-cycle pulse on a debounced 1→0 transition.
- `evt_o`  out  `channels`  sticky press flag; set by rise, held until cleared.
- `evt_clr_i`  in  `channels`  per-channel clear of `evt_o`, sampled each cycle.
- `irq_o`  out  1  registered OR of all `evt_o` bits.

## Operation
- **Reset.** All registers clear when `reset` is sampled high at a rising edge:
  - `btn_o`, `rise_o`, `fall_o`, `evt_o`, `irq_o` = 0;
  - synchroniser flops = 0;
  - counters = 0.
- **Synchroniser.** Per channel, two flops: `s1 <= btn_i`, `s2 <= s1`. Only `s2` feeds the debouncer.
- **Debouncer.** Per channel, a counter of width ceil(log2(`debounce_cycles`)). The two channel states are STABLE (`s2 == btn_o`) and PENDING (`s2 != btn_o`).
  - **STABLE:** `cnt <= 0`.
  - **PENDING, `cnt != debounce_cycles-1`:** `cnt <= cnt+1`.
  - **PENDING, `cnt == debounce_cycles-1`:** `btn_o <= s2`, `cnt <= 0`, and the matching edge pulse is asserted on this same edge.
    - `rise_o` is asserted if `s2` = 1.
    - `fall_o` is asserted if `s2` = 0.
- **Glitch rejection.** Any return of `s2` to `btn_o` before terminal count sends the channel to STABLE and clears `cnt`. No output changes and no partial count is retained.
- **Edge pulses.**
  - `rise_o[n]` and `fall_o[n]` are high for exactly one cycle.
  - They are never both high for the same channel.
  - They default to 0 every cycle.
- **Event flag.**
  - `evt_o[n]` is set on the edge that asserts `rise_o[n]`.
  - It is cleared on an edge where `evt_clr_i[n]` = 1 and no rise occurs.
  - Simultaneous rise and clear: set wins, so `evt_o[n]` stays 1.
  - Clear of an already-clear flag: no effect.
  - Falls never touch `evt_o`.
- **Interrupt.** `irq_o <= |evt_o_next`, i.e. updated on the same edge as `evt_o`.
- **Channel independence.** Channels share no state; simultaneous activity on all channels is handled in parallel.
- **Reset mid-count.** Counter and outputs clear. A button still held after reset is re-qualified from 0 and produces a fresh rise and event.

## Timing
- Input change sampled into `s1` at edge #1; `s2` changes at edge #2; counting starts at edge #3.
- `btn_o`, the edge pulse and `evt_o` update at edge #(`debounce_cycles`+2).
  - Latency is `debounce_cycles`+2 cycles from the first sampling edge.
  - Add one cycle of uncertainty for asynchronous input.
- Minimum stable input width that propagates: `debounce_cycles` cycles at `s2`. Shorter pulses are always rejected.
- `irq_o` is coincident with `evt_o`, with no extra cycle.
- `evt_clr_i` takes effect at the next edge, giving one-cycle clear latency.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Bench uses `debounce_cycles`=4, `channels`=4.

1. **Reset.** Hold `reset` 3 cycles with `btn_i`=4'hF → all outputs 0 during reset. `btn_o`=4'hF, `rise_o`=4'hF for one cycle, and `evt_o`=4'hF at the 6th edge after release.
2. **Clean press/release.** Drive `btn_i[0]` 0→1, hold 20 cycles, then release.
   - Press: `btn_o[0]` and a 1-cycle `rise_o[0]` at edge #6; `evt_o[0]`=1 and `irq_o`=1 on that edge.
   - Release: `fall_o[0]` at edge #6 after release; `evt_o[0]` stays 1.
3. **Bounce rejection.** `btn_i[1]` toggles with high widths 3,2,3 separated by 1-cycle lows, then stays high.
   - No `btn_o[1]` change during the bouncing.
   - Single `rise_o[1]` exactly 6 edges after the final low→high.
4. **Clear versus set.**
   - With `evt_o[2]`=1, pulse `evt_clr_i[2]` one cycle → `evt_o[2]`=0, and `irq_o`=0 if no other flag is set.
   - Assert `evt_clr_i[3]` on the same edge as `rise_o[3]` → `evt_o[3]`=1.
5. **Reset mid-count.** Raise `btn_i[0]` and assert `reset` at edge #4 for 1 cycle → no rise during the sequence. `rise_o[0]` 6 edges after reset deasserts.
6. **Parallel channels.** `btn_i`=4'hF applied at one edge → `rise_o`=4'hF in one cycle and `evt_o`=4'hF; `irq_o`=1.
